// File: rtl/wb_pkg.sv
// Shared constants, the default write-back entry type and the round-robin pick
// function for the write-back arbiter.
package wb_pkg;

   localparam int REG_ADDR_W   = 5;
   localparam int XLEN_DEFAULT = 32;
   localparam int MAX_SRC      = 8;

   typedef struct packed {
      logic [REG_ADDR_W-1:0]   rd;
      logic [XLEN_DEFAULT-1:0] data;
   } wb_entry_t;

   // Search starts one past the last winner and wraps at n_src; first requester wins.
   function automatic logic [MAX_SRC-1:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                                  input int ptr,
                                                  input int n_src);
      logic [MAX_SRC-1:0] gnt;
      logic [2:0]         idx;
      gnt = '0;
      for (int k = 1; k <= MAX_SRC; k++) begin
         if (k <= n_src) begin
            idx = 3'((ptr + k) % n_src);
            if (gnt == '0 && req[idx]) gnt[idx] = 1'b1;
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source result FIFO: power-of-two depth, no pass-through, so a full FIFO
// stays not-ready even when it is popped in the same cycle.
module wb_fifo import wb_pkg::*; #(
   parameter int  DEPTH   = 2,
   parameter type entry_t = wb_entry_t
) (
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   push_i,
   input  entry_t push_data_i,
   input  logic   pop_i,
   output logic   full_o,
   output logic   empty_o,
   output entry_t head_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

   entry_t        mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          push_ok;
   logic          pop_ok;

   assign full_o  = (cnt_q == CNT_MAX);
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: per-source FIFOs, round-robin grant, registered single write port.
// Define WB_BYPASS_EN to add the combinational read-bypass ports for the dispatcher.
module wb_arbiter import wb_pkg::*; #(
   parameter int N_SRC = 4,
   parameter int DEPTH = 2,
   parameter int XLEN  = XLEN_DEFAULT
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_SRC-1:0]            SRC_VALID,
   output logic [N_SRC-1:0]            SRC_READY,
   input  logic [N_SRC*REG_ADDR_W-1:0] SRC_RD,
   input  logic [N_SRC*XLEN-1:0]       SRC_DATA,
   output logic                        WB_WE,
   output logic [REG_ADDR_W-1:0]       WB_RD,
   output logic [XLEN-1:0]             WB_DATA,
   output logic [N_SRC-1:0]            WB_GRANT
`ifdef WB_BYPASS_EN
   ,
   input  logic [REG_ADDR_W-1:0]       BYP_RS1,
   input  logic [REG_ADDR_W-1:0]       BYP_RS2,
   output logic                        BYP_RS1_HIT,
   output logic                        BYP_RS2_HIT,
   output logic [XLEN-1:0]             BYP_RS1_DATA,
   output logic [XLEN-1:0]             BYP_RS2_DATA
`endif
);

   localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } entry_t;

   entry_t                  push_data [N_SRC];
   entry_t                  head      [N_SRC];
   entry_t                  sel;
   logic [N_SRC-1:0]        full, empty, push, pop;
   logic [MAX_SRC-1:0]      pick;
   logic                    unused_pick;
   logic [PTR_W-1:0]        ptr_q, ptr_d;
   logic                    we_q, we_d;
   logic [REG_ADDR_W-1:0]   rd_q, rd_d;
   logic [XLEN-1:0]         data_q, data_d;
   logic [N_SRC-1:0]        grant_q, grant_d;

   for (genvar g = 0; g < N_SRC; g++) begin : g_src
      assign push_data[g] = '{rd:   SRC_RD[g*REG_ADDR_W +: REG_ADDR_W],
                              data: SRC_DATA[g*XLEN +: XLEN]};
      assign push[g]      = SRC_VALID[g] & ~full[g];

      wb_fifo #(
         .DEPTH   (DEPTH),
         .entry_t (entry_t)
      ) u_fifo (
         .clk_i       (clk),
         .rst_i       (rst),
         .push_i      (push[g]),
         .push_data_i (push_data[g]),
         .pop_i       (pop[g]),
         .full_o      (full[g]),
         .empty_o     (empty[g]),
         .head_o      (head[g])
      );
   end

   // Ready is a pure function of FIFO occupancy; valid never feeds back into it.
   assign SRC_READY   = ~full;
   assign pick        = rr_pick(MAX_SRC'(~empty), int'(ptr_q), N_SRC);
   assign pop         = pick[N_SRC-1:0];
   assign unused_pick = ^pick;

   always_comb begin
      ptr_d   = ptr_q;
      we_d    = 1'b0;
      grant_d = '0;
      rd_d    = rd_q;
      data_d  = data_q;
      sel     = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (pop[i]) begin
            sel   = head[i];
            ptr_d = PTR_W'(i);
         end
      end
      if (|pop) begin
         grant_d = pop;
         rd_d    = sel.rd;
         data_d  = sel.data;
         we_d    = (sel.rd != '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= PTR_W'(N_SRC - 1);
         we_q    <= 1'b0;
         rd_q    <= '0;
         data_q  <= '0;
         grant_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         we_q    <= we_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
         grant_q <= grant_d;
      end
   end

   assign WB_WE    = we_q;
   assign WB_RD    = rd_q;
   assign WB_DATA  = data_q;
   assign WB_GRANT = grant_q;

`ifdef WB_BYPASS_EN
   assign BYP_RS1_HIT  = we_q && (rd_q == BYP_RS1) && (BYP_RS1 != '0);
   assign BYP_RS2_HIT  = we_q && (rd_q == BYP_RS2) && (BYP_RS2 != '0);
   assign BYP_RS1_DATA = data_q;
   assign BYP_RS2_DATA = data_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (N_SRC=4, DEPTH=2, XLEN=32).
module tb_wb_arbiter;

   localparam int N_SRC = 4;
   localparam int DEPTH = 2;
   localparam int XLEN  = 32;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [N_SRC-1:0]      src_valid;
   logic [N_SRC-1:0]      src_ready;
   logic [N_SRC*5-1:0]    src_rd;
   logic [N_SRC*XLEN-1:0] src_data;
   logic                  wb_we;
   logic [4:0]            wb_rd;
   logic [XLEN-1:0]       wb_data;
   logic [N_SRC-1:0]      wb_grant;
`ifdef WB_BYPASS_EN
   logic [4:0]            byp_rs1, byp_rs2;
   logic                  byp_rs1_hit, byp_rs2_hit;
   logic [XLEN-1:0]       byp_rs1_data, byp_rs2_data;
`endif

   int n_checks = 0;
   int n_errors = 0;
   // {grant[3:0], rd[4:0], data[31:0]}
   logic [40:0] exp_q [$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   wb_arbiter #(
      .N_SRC (N_SRC),
      .DEPTH (DEPTH),
      .XLEN  (XLEN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .SRC_VALID (src_valid),
      .SRC_READY (src_ready),
      .SRC_RD    (src_rd),
      .SRC_DATA  (src_data),
      .WB_WE     (wb_we),
      .WB_RD     (wb_rd),
      .WB_DATA   (wb_data),
      .WB_GRANT  (wb_grant)
`ifdef WB_BYPASS_EN
      ,
      .BYP_RS1      (byp_rs1),
      .BYP_RS2      (byp_rs2),
      .BYP_RS1_HIT  (byp_rs1_hit),
      .BYP_RS2_HIT  (byp_rs2_hit),
      .BYP_RS1_DATA (byp_rs1_data),
      .BYP_RS2_DATA (byp_rs2_data)
`endif
   );

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_src(input int s, input logic v, input logic [4:0] rd,
                            input logic [31:0] d);
      src_valid[s]          = v;
      src_rd[s*5 +: 5]      = rd;
      src_data[s*XLEN +: XLEN] = d;
   endtask

   // ---------------- scoreboard ----------------
   task automatic expect_wb(input logic [3:0] g, input logic [4:0] rd, input logic [31:0] d);
      exp_q.push_back({g, rd, d});
   endtask

   task automatic check_pop(input string tag);
      logic [40:0] e;
      e = exp_q.pop_front();
      check({tag, "_grant"}, wb_grant, e[40:37]);
      check({tag, "_we"},    wb_we,    (e[36:32] != 5'd0));
      check({tag, "_rd"},    wb_rd,    e[36:32]);
      check({tag, "_data"},  wb_data,  e[31:0]);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_we"},    wb_we,    1'b0);
      check({tag, "_grant"}, wb_grant, 4'b0000);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      src_valid = '0;
      src_rd    = '0;
      src_data  = '0;
`ifdef WB_BYPASS_EN
      byp_rs1 = '0;
      byp_rs2 = '0;
`endif

      // Reset state while held
      repeat (3) @(posedge clk);
      #1;
      check("rst_we",    wb_we,    1'b0);
      check("rst_grant", wb_grant, 4'b0000);
      check("rst_rd",    wb_rd,    5'd0);
      check("rst_data",  wb_data,  32'h0);
      check("rst_ready", src_ready, 4'b1111);
      rst = 1'b0;

      // Idle after release
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_ready", src_ready, 4'b1111);
         check_idle("idle");
      end

      // Single push src2: loaded one edge after the push edge
      drive_src(2, 1'b1, 5'd5, 32'hDEADBEEF);
      tick();
      src_valid = '0;
      check("single_e0_we", wb_we, 1'b0);
      tick();
      expect_wb(4'b0100, 5'd5, 32'hDEADBEEF);
      check_pop("single_e1");
      tick();
      check_idle("single_after");
      check("single_hold_rd",   wb_rd,   5'd5);
      check("single_hold_data", wb_data, 32'hDEADBEEF);

      // Asynchronous reset mid-burst
      for (int s = 0; s < N_SRC; s++) drive_src(s, 1'b1, 5'(s + 1), 32'hB000 + s);
      tick();
      tick();
      src_valid = '0;
      check("burst_we_before_rst", wb_we, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("arst_we",    wb_we,    1'b0);
      check("arst_grant", wb_grant, 4'b0000);
      check("arst_rd",    wb_rd,    5'd0);
      check("arst_data",  wb_data,  32'h0);
      check("arst_ready", src_ready, 4'b1111);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_idle("arst_flushed");
         check("arst_flushed_ready", src_ready, 4'b1111);
      end

      // Fairness: all sources push two entries, grants 0,1,2,3,0,1,2,3
      for (int s = 0; s < N_SRC; s++) drive_src(s, 1'b1, 5'(s + 1), 32'h1000_0000 + s);
      tick();
      check("rr_ready_e0", src_ready, 4'b1111);
      check_idle("rr_e0");
      for (int s = 0; s < N_SRC; s++) drive_src(s, 1'b1, 5'(s + 5), 32'h2000_0000 + s);
      tick();
      src_valid = '0;
      check("rr_ready_e1", src_ready, 4'b0001);
      for (int s = 0; s < N_SRC; s++) expect_wb(4'(1 << s), 5'(s + 1), 32'h1000_0000 + s);
      for (int s = 0; s < N_SRC; s++) expect_wb(4'(1 << s), 5'(s + 5), 32'h2000_0000 + s);
      for (int k = 0; k < 8; k++) begin
         check_pop("rr");
         tick();
      end
      check_idle("rr_done");
      check("rr_q_empty", exp_q.size(), 0);

      // Full src1 stalls while src0 competes; held valid accepted only after a pop
      drive_src(0, 1'b1, 5'd10, 32'h5000_0000);
      drive_src(1, 1'b1, 5'd11, 32'hA000_0001);
      tick();
      check("stall_rdy1_e1", src_ready[1], 1'b1);
      check_idle("stall_e1");
      drive_src(0, 1'b1, 5'd10, 32'h5000_0001);
      drive_src(1, 1'b1, 5'd11, 32'hA000_0002);
      tick();
      check("stall_rdy1_full", src_ready[1], 1'b0);
      drive_src(0, 1'b1, 5'd10, 32'h5000_0002);
      drive_src(1, 1'b1, 5'd11, 32'hA000_0003);
      expect_wb(4'b0001, 5'd10, 32'h5000_0000);
      expect_wb(4'b0010, 5'd11, 32'hA000_0001);
      expect_wb(4'b0001, 5'd10, 32'h5000_0001);
      expect_wb(4'b0010, 5'd11, 32'hA000_0002);
      expect_wb(4'b0001, 5'd10, 32'h5000_0002);
      expect_wb(4'b0010, 5'd11, 32'hA000_0003);
      check_pop("stall");
      tick();
      src_valid[0] = 1'b0;
      check("stall_rdy1_after_pop", src_ready[1], 1'b1);
      check_pop("stall");
      tick();
      src_valid[1] = 1'b0;
      check("stall_rdy1_refull", src_ready[1], 1'b0);
      for (int k = 0; k < 4; k++) begin
         check_pop("stall");
         tick();
      end
      check_idle("stall_done");
      check("stall_q_empty", exp_q.size(), 0);

      // x0 destination: granted but not written
      drive_src(3, 1'b1, 5'd0, 32'h0000_1234);
      tick();
      drive_src(3, 1'b1, 5'd7, 32'h0000_5678);
      tick();
      src_valid = '0;
      expect_wb(4'b1000, 5'd0, 32'h0000_1234);
      expect_wb(4'b1000, 5'd7, 32'h0000_5678);
      check_pop("x0");
      tick();
      check_pop("x0_next");
      tick();
      check_idle("x0_done");

`ifdef WB_BYPASS_EN
      drive_src(0, 1'b1, 5'd9, 32'hA5A5A5A5);
      tick();
      src_valid = '0;
      byp_rs1 = 5'd9;
      byp_rs2 = 5'd0;
      tick();
      check("byp_we",       wb_we,        1'b1);
      check("byp_rs1_hit",  byp_rs1_hit,  1'b1);
      check("byp_rs1_data", byp_rs1_data, 32'hA5A5A5A5);
      check("byp_rs2_hit",  byp_rs2_hit,  1'b0);
      byp_rs2 = 5'd9;
      #1;
      check("byp_rs2_hit9", byp_rs2_hit,  1'b1);
      check("byp_rs2_data", byp_rs2_data, 32'hA5A5A5A5);
      tick();
      check("byp_rs1_nowe", byp_rs1_hit,  1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
